// File: rtl/hpu_pkg.sv
// hpu_pkg: shared HPU scalar types, DTCM address map and DTCM arbitration source enum.
package hpu_pkg;
    typedef logic [31:0] pc_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  data_strobe_t;
    localparam int  DTCM_DEPTH      = 4096;
    localparam pc_t MEM_DTCM_ADDR_S = 32'h0010_0000;
    localparam pc_t MEM_DTCM_ADDR_E = 32'h0010_3fff;
    typedef logic [$clog2(DTCM_DEPTH)-1:0] dtcm_idx_t;
    typedef enum logic [1:0] {NONE, LSU_WR, LSU_RD, EXT} dtcm_src_e;
endpackage

// File: rtl/hpu_dtcm_ctrl_if.sv
// hpu_dtcm_ctrl_if: external (DMA/NoC) slave port of the DTCM.
interface hpu_dtcm_ctrl_if;
    import hpu_pkg::*;
    logic         req;
    logic         we;
    pc_t          addr;
    data_t        wdata;
    data_strobe_t wstrb;
    logic         gnt;
    logic         rvalid;
    data_t        rdata;
    modport master (output req, we, addr, wdata, wstrb, input gnt, rvalid, rdata);
    modport slave (input req, we, addr, wdata, wstrb, output gnt, rvalid, rdata);
endinterface

// File: rtl/hpu_dtcm_sram.sv
// hpu_dtcm_sram: single-port byte-strobed write-first SRAM model with 1-cycle registered read.
module hpu_dtcm_sram
    import hpu_pkg::*;
#(
    parameter int DEPTH = DTCM_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  data_t                    wdata_i,
    input  data_strobe_t             wstrb_i,
    output data_t                    rdata_o
);
    data_t mem_q [DEPTH];
    data_t wr_word;
    data_t rdata_q;

    always_comb begin
        wr_word = mem_q[idx_i];
        for (int b = 0; b < 4; b++)
            if (wstrb_i[b]) wr_word[8*b+:8] = wdata_i[8*b+:8];
    end

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) mem_q[idx_i] <= wr_word;
            rdata_q <= we_i ? wr_word : mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/hpu_dtcm_ctrl.sv
// hpu_dtcm_ctrl: DTCM target controller - LSU/ext arbitration, starvation guard, LR/SC reservation, response pipeline.
module hpu_dtcm_ctrl
    import hpu_pkg::*;
#(
    parameter int DEPTH      = DTCM_DEPTH,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         lsu_dtcm__wr_en_i,
    input  logic         lsu_dtcm__wr_rls_lock_i,
    input  pc_t          lsu_dtcm__waddr_i,
    input  data_t        lsu_dtcm__wdata_i,
    input  data_strobe_t lsu_dtcm__wstrb_i,
    output logic         dtcm_lsu__wr_suc_o,
    output logic         dtcm_lsu__sc_fail_o,
    input  logic         lsu_dtcm__rd_en_i,
    input  logic         lsu_dtcm__rd_acq_lock_i,
    input  pc_t          lsu_dtcm__raddr_i,
    output logic         dtcm_lsu__rd_suc_o,
    output data_t        dtcm_lsu__rdata_o,
    hpu_dtcm_ctrl_if.slave ext
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_MAX + 1);

    dtcm_src_e    src_d, src_q;
    logic [CW-1:0] starve_d, starve_q;
    logic          rsv_vld_d, rsv_vld_q;
    logic [AW-1:0] rsv_idx_d, rsv_idx_q;
    logic          sc_fail_d, sc_fail_q;
    logic          ext_rd_q, rvalid_q;
    data_t         rdata_q, ext_rdata_q;
    logic [AW-1:0] widx, ridx, eidx, sidx;
    logic          starved, sc_ok, s_we;
    data_t         s_wdata, s_rdata;
    data_strobe_t  s_strb;

    assign widx    = AW'((lsu_dtcm__waddr_i - MEM_DTCM_ADDR_S) >> 2);
    assign ridx    = AW'((lsu_dtcm__raddr_i - MEM_DTCM_ADDR_S) >> 2);
    assign eidx    = AW'((ext.addr - MEM_DTCM_ADDR_S) >> 2);
    assign starved = ext.req && starve_q == CW'(STARVE_MAX);
    assign sc_ok   = rsv_vld_q && rsv_idx_q == widx;

    // Nothing is granted while reset is held, so no access slips through.
    always_comb begin
        src_d = rst_i ? NONE : starved ? EXT : lsu_dtcm__wr_en_i ? LSU_WR :
                lsu_dtcm__rd_en_i ? LSU_RD : ext.req ? EXT : NONE;
        s_we = src_d == LSU_WR ? !(lsu_dtcm__wr_rls_lock_i && !sc_ok) : src_d == EXT && ext.we;
        sidx = src_d == LSU_WR ? widx : src_d == LSU_RD ? ridx : eidx;
        s_wdata = src_d == EXT ? ext.wdata : lsu_dtcm__wdata_i;
        s_strb = src_d == EXT ? ext.wstrb : lsu_dtcm__wstrb_i;
        sc_fail_d = src_d == LSU_WR && lsu_dtcm__wr_rls_lock_i && !sc_ok;
        starve_d = src_d == EXT ? '0 : ext.req ? starve_q + CW'(1) : starve_q;
        rsv_vld_d = rsv_vld_q;
        rsv_idx_d = rsv_idx_q;
        if (src_d == LSU_RD && lsu_dtcm__rd_acq_lock_i) begin
            rsv_vld_d = 1'b1;
            rsv_idx_d = ridx;
        end
        if (src_d == LSU_WR && (lsu_dtcm__wr_rls_lock_i || (|lsu_dtcm__wstrb_i && widx == rsv_idx_q)))
            rsv_vld_d = 1'b0;
        if (src_d == EXT && ext.we && |ext.wstrb && eidx == rsv_idx_q)
            rsv_vld_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_q       <= NONE;
            starve_q    <= '0;
            rsv_vld_q   <= 1'b0;
            rsv_idx_q   <= '0;
            sc_fail_q   <= 1'b0;
            ext_rd_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            ext_rdata_q <= '0;
        end else begin
            src_q     <= src_d;
            starve_q  <= starve_d;
            rsv_vld_q <= rsv_vld_d;
            rsv_idx_q <= rsv_idx_d;
            sc_fail_q <= sc_fail_d;
            ext_rd_q  <= src_d == EXT && !ext.we;
            rvalid_q  <= ext_rd_q;
            if (src_q == LSU_RD) rdata_q <= s_rdata;
            if (ext_rd_q) ext_rdata_q <= s_rdata;
        end
    end

    hpu_dtcm_sram #(.DEPTH(DEPTH)) u_sram (
        .clk_i   (clk_i),
        .en_i    (src_d != NONE),
        .we_i    (s_we),
        .idx_i   (sidx),
        .wdata_i (s_wdata),
        .wstrb_i (s_strb),
        .rdata_o (s_rdata)
    );

    assign ext.gnt             = src_d == EXT;
    assign ext.rvalid          = rvalid_q;
    assign ext.rdata           = ext_rdata_q;
    assign dtcm_lsu__wr_suc_o  = src_q == LSU_WR;
    assign dtcm_lsu__rd_suc_o  = src_q == LSU_RD;
    assign dtcm_lsu__sc_fail_o = sc_fail_q;
    assign dtcm_lsu__rdata_o   = rdata_q;
endmodule

// File: tb/tb_hpu_dtcm_ctrl.sv
// tb_hpu_dtcm_ctrl: directed scenarios plus randomized traffic against a behavioural DTCM model.
module tb_hpu_dtcm_ctrl;
    import hpu_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         wr_en, rls, rd_en, acq;
    pc_t          waddr, raddr;
    data_t        wdata;
    data_strobe_t wstrb;
    logic         wr_suc, sc_fail, rd_suc;
    data_t        rdata;
    int           pass_cnt = 0;
    int           total_cnt = 0;

    hpu_dtcm_ctrl_if ext_if();

    hpu_dtcm_ctrl #(.DEPTH(4096), .STARVE_MAX(4)) dut (
        .clk_i                   (clk_i),
        .rst_i                   (rst_i),
        .lsu_dtcm__wr_en_i       (wr_en),
        .lsu_dtcm__wr_rls_lock_i (rls),
        .lsu_dtcm__waddr_i       (waddr),
        .lsu_dtcm__wdata_i       (wdata),
        .lsu_dtcm__wstrb_i       (wstrb),
        .dtcm_lsu__wr_suc_o      (wr_suc),
        .dtcm_lsu__sc_fail_o     (sc_fail),
        .lsu_dtcm__rd_en_i       (rd_en),
        .lsu_dtcm__rd_acq_lock_i (acq),
        .lsu_dtcm__raddr_i       (raddr),
        .dtcm_lsu__rd_suc_o      (rd_suc),
        .dtcm_lsu__rdata_o       (rdata),
        .ext                     (ext_if)
    );

    always #5 clk_i = ~clk_i;

    function automatic pc_t wa(int i);
        return MEM_DTCM_ADDR_S + pc_t'(4 * i);
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        wr_en = 0; rls = 0; rd_en = 0; acq = 0;
        waddr = wa(0); raddr = wa(0); wdata = '0; wstrb = '0;
        ext_if.req = 0; ext_if.we = 0; ext_if.addr = wa(0); ext_if.wdata = '0; ext_if.wstrb = '0;
    endtask

    task automatic lsu_wr(int i, data_t d, data_strobe_t s, logic l);
        wr_en = 1; waddr = wa(i); wdata = d; wstrb = s; rls = l;
    endtask

    task automatic lsu_rd(int i, logic a);
        rd_en = 1; raddr = wa(i); acq = a;
    endtask

    task automatic test_reset();
        rst_i = 1; idle(); step(); step();
        total_cnt++; if (wr_suc !== 1'b0) $display("FAIL reset_wr_suc: got %b want 0", wr_suc); else pass_cnt++;
        total_cnt++; if (rd_suc !== 1'b0) $display("FAIL reset_rd_suc: got %b want 0", rd_suc); else pass_cnt++;
        total_cnt++; if (sc_fail !== 1'b0) $display("FAIL reset_sc_fail: got %b want 0", sc_fail); else pass_cnt++;
        total_cnt++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata); else pass_cnt++;
        total_cnt++; if (ext_if.gnt !== 1'b0) $display("FAIL reset_gnt: got %b want 0", ext_if.gnt); else pass_cnt++;
        total_cnt++; if (ext_if.rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", ext_if.rvalid); else pass_cnt++;
        total_cnt++; if (ext_if.rdata !== 32'h0) $display("FAIL reset_ext_rdata: got %h want 0", ext_if.rdata); else pass_cnt++;
        rst_i = 0;
    endtask

    task automatic test_write_read();
        idle(); lsu_wr(2, 32'hDEADBEEF, 4'hF, 0); step();
        total_cnt++; if (wr_suc !== 1'b1) $display("FAIL wr_wr_suc: got %b want 1", wr_suc); else pass_cnt++;
        total_cnt++; if (rd_suc !== 1'b0) $display("FAIL wr_rd_suc_idle: got %b want 0", rd_suc); else pass_cnt++;
        idle(); lsu_rd(2, 0); step();
        total_cnt++; if (rd_suc !== 1'b1) $display("FAIL rd_rd_suc: got %b want 1", rd_suc); else pass_cnt++;
        total_cnt++; if (wr_suc !== 1'b0) $display("FAIL rd_wr_suc_idle: got %b want 0", wr_suc); else pass_cnt++;
        idle(); step();
        total_cnt++; if (rdata !== 32'hDEADBEEF) $display("FAIL raw_rdata: got %h want deadbeef", rdata); else pass_cnt++;
    endtask

    task automatic test_strobe();
        idle(); lsu_wr(3, 32'h11223344, 4'hF, 0); step();
        idle(); lsu_wr(3, 32'h0000AA00, 4'h2, 0); step();
        total_cnt++; if (wr_suc !== 1'b1) $display("FAIL strb_wr_suc: got %b want 1", wr_suc); else pass_cnt++;
        idle(); lsu_rd(3, 0); step();
        idle(); step();
        total_cnt++; if (rdata !== 32'h1122AA44) $display("FAIL strb_rdata: got %h want 1122aa44", rdata); else pass_cnt++;
    endtask

    task automatic test_rd_wr_collision();
        idle(); lsu_wr(4, 32'h55, 4'hF, 0); lsu_rd(2, 0); step();
        total_cnt++; if (wr_suc !== 1'b1) $display("FAIL coll_wr_suc: got %b want 1", wr_suc); else pass_cnt++;
        total_cnt++; if (rd_suc !== 1'b0) $display("FAIL coll_rd_suc: got %b want 0", rd_suc); else pass_cnt++;
        idle(); lsu_rd(2, 0); step();
        total_cnt++; if (rd_suc !== 1'b1) $display("FAIL coll_retry_rd_suc: got %b want 1", rd_suc); else pass_cnt++;
        idle(); step();
        total_cnt++; if (rdata !== 32'hDEADBEEF) $display("FAIL coll_retry_rdata: got %h want deadbeef", rdata); else pass_cnt++;
    endtask

    task automatic test_lr_sc();
        idle(); lsu_rd(5, 1); step();
        total_cnt++; if (rd_suc !== 1'b1) $display("FAIL lr_rd_suc: got %b want 1", rd_suc); else pass_cnt++;
        idle(); lsu_wr(5, 32'hCAFEF00D, 4'hF, 1); step();
        total_cnt++; if (wr_suc !== 1'b1) $display("FAIL sc_wr_suc: got %b want 1", wr_suc); else pass_cnt++;
        total_cnt++; if (sc_fail !== 1'b0) $display("FAIL sc_ok_fail: got %b want 0", sc_fail); else pass_cnt++;
        idle(); lsu_wr(5, 32'h0, 4'hF, 1); step();
        total_cnt++; if (sc_fail !== 1'b1) $display("FAIL sc_again_fail: got %b want 1", sc_fail); else pass_cnt++;
        idle(); lsu_rd(5, 0); step();
        idle(); step();
        total_cnt++; if (rdata !== 32'hCAFEF00D) $display("FAIL sc_rdata: got %h want cafef00d", rdata); else pass_cnt++;
    endtask

    task automatic test_lr_ext_sc();
        idle(); lsu_rd(6, 1); step();
        idle();
        ext_if.req = 1; ext_if.we = 1; ext_if.addr = wa(6) + 32'd1; ext_if.wdata = 32'h12345678; ext_if.wstrb = 4'hF;
        #1;
        total_cnt++; if (ext_if.gnt !== 1'b1) $display("FAIL extwr_gnt: got %b want 1", ext_if.gnt); else pass_cnt++;
        step();
        idle(); lsu_wr(6, 32'h0BADBEEF, 4'hF, 1); step();
        total_cnt++; if (wr_suc !== 1'b1) $display("FAIL extsc_wr_suc: got %b want 1", wr_suc); else pass_cnt++;
        total_cnt++; if (sc_fail !== 1'b1) $display("FAIL extsc_fail: got %b want 1", sc_fail); else pass_cnt++;
        idle(); lsu_rd(6, 0); step();
        idle(); step();
        total_cnt++; if (rdata !== 32'h12345678) $display("FAIL extsc_rdata: got %h want 12345678", rdata); else pass_cnt++;
    endtask

    task automatic test_starvation();
        idle();
        ext_if.req = 1; ext_if.we = 0; ext_if.addr = wa(2);
        for (int c = 1; c <= 5; c++) begin
            lsu_rd(3, 0);
            #1;
            total_cnt++; if (ext_if.gnt !== (c == 5)) $display("FAIL starve_gnt c%0d: got %b want %b", c, ext_if.gnt, c == 5); else pass_cnt++;
            step();
            total_cnt++; if (rd_suc !== (c != 5)) $display("FAIL starve_rd_suc c%0d: got %b want %b", c, rd_suc, c != 5); else pass_cnt++;
        end
        total_cnt++; if (ext_if.rvalid !== 1'b0) $display("FAIL starve_rvalid_t1: got %b want 0", ext_if.rvalid); else pass_cnt++;
        idle(); step();
        total_cnt++; if (ext_if.rvalid !== 1'b1) $display("FAIL starve_rvalid_t2: got %b want 1", ext_if.rvalid); else pass_cnt++;
        total_cnt++; if (ext_if.rdata !== 32'hDEADBEEF) $display("FAIL starve_ext_rdata: got %h want deadbeef", ext_if.rdata); else pass_cnt++;
        step();
        total_cnt++; if (ext_if.rvalid !== 1'b0) $display("FAIL starve_rvalid_t3: got %b want 0", ext_if.rvalid); else pass_cnt++;
        ext_if.req = 1; ext_if.we = 0; ext_if.addr = wa(3); step();
        rst_i = 1; lsu_rd(2, 0); step();
        total_cnt++; if (ext_if.rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b want 0", ext_if.rvalid); else pass_cnt++;
        total_cnt++; if (ext_if.gnt !== 1'b0) $display("FAIL rst_gnt: got %b want 0", ext_if.gnt); else pass_cnt++;
        total_cnt++; if (ext_if.rdata !== 32'h0) $display("FAIL rst_ext_rdata: got %h want 0", ext_if.rdata); else pass_cnt++;
        total_cnt++; if (rd_suc !== 1'b0) $display("FAIL rst_rd_suc: got %b want 0", rd_suc); else pass_cnt++;
        total_cnt++; if (wr_suc !== 1'b0) $display("FAIL rst_wr_suc: got %b want 0", wr_suc); else pass_cnt++;
        total_cnt++; if (sc_fail !== 1'b0) $display("FAIL rst_sc_fail: got %b want 0", sc_fail); else pass_cnt++;
        total_cnt++; if (rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", rdata); else pass_cnt++;
        rst_i = 0; idle(); step();
        total_cnt++; if (ext_if.rvalid !== 1'b0) $display("FAIL post_rst_rvalid: got %b want 0", ext_if.rvalid); else pass_cnt++;
        total_cnt++; if (rd_suc !== 1'b0) $display("FAIL post_rst_rd_suc: got %b want 0", rd_suc); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] mem_m [4];
        logic  rsv_v, prev_rd, prev_er;
        int    rsv_i, cnt_m;
        data_t exp_rd, exp_erd, prev_rv, prev_ev;
        rsv_v = 0; rsv_i = 0; cnt_m = 0; prev_rd = 0; prev_er = 0;
        exp_rd = '0; exp_erd = '0; prev_rv = '0; prev_ev = '0;
        rst_i = 1; idle(); step(); rst_i = 0;
        for (int n = 0; n < 300; n++) begin
            int widx, ridx, eidx, win;
            logic ok;
            data_t rv, ev;
            idle();
            widx = $urandom_range(0, 3); ridx = $urandom_range(0, 3); eidx = $urandom_range(0, 3);
            if (n < 4) begin
                widx = n;
                lsu_wr(n, $urandom, 4'hF, 0);
            end else begin
                if ($urandom_range(0, 9) < 4) lsu_wr(widx, $urandom, data_strobe_t'($urandom), $urandom_range(0, 9) < 3);
                if ($urandom_range(0, 1) == 1) lsu_rd(ridx, $urandom_range(0, 9) < 4);
                waddr = waddr + pc_t'($urandom_range(0, 3));
                raddr = raddr + pc_t'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 1) begin
                    ext_if.req = 1; ext_if.we = 1'($urandom_range(0, 1));
                    ext_if.addr = wa(eidx) + pc_t'($urandom_range(0, 3));
                    ext_if.wdata = $urandom; ext_if.wstrb = data_strobe_t'($urandom);
                end
            end
            win = 0; ok = 0; rv = '0; ev = '0;
            if (ext_if.req && cnt_m == 4) win = 3;
            else if (wr_en) win = 1;
            else if (rd_en) win = 2;
            else if (ext_if.req) win = 3;
            if (win == 1) begin
                ok = rsv_v && rsv_i == widx;
                if (!rls || ok)
                    for (int b = 0; b < 4; b++) if (wstrb[b]) mem_m[widx][8*b+:8] = wdata[8*b+:8];
                if (rls || (wstrb != 0 && rsv_i == widx)) rsv_v = 0;
            end
            if (win == 2) begin
                rv = mem_m[ridx];
                if (acq) begin rsv_v = 1; rsv_i = ridx; end
            end
            if (win == 3 && ext_if.we) begin
                for (int b = 0; b < 4; b++) if (ext_if.wstrb[b]) mem_m[eidx][8*b+:8] = ext_if.wdata[8*b+:8];
                if (ext_if.wstrb != 0 && rsv_i == eidx) rsv_v = 0;
            end
            if (win == 3 && !ext_if.we) ev = mem_m[eidx];
            cnt_m = win == 3 ? 0 : ext_if.req ? cnt_m + 1 : cnt_m;
            #1;
            total_cnt++; if (ext_if.gnt !== (win == 3)) $display("FAIL rnd_gnt n%0d: got %b want %b", n, ext_if.gnt, win == 3); else pass_cnt++;
            step();
            total_cnt++; if (wr_suc !== (win == 1)) $display("FAIL rnd_wr_suc n%0d: got %b want %b", n, wr_suc, win == 1); else pass_cnt++;
            total_cnt++; if (rd_suc !== (win == 2)) $display("FAIL rnd_rd_suc n%0d: got %b want %b", n, rd_suc, win == 2); else pass_cnt++;
            total_cnt++; if (sc_fail !== (win == 1 && rls && !ok)) $display("FAIL rnd_sc_fail n%0d: got %b want %b", n, sc_fail, win == 1 && rls && !ok); else pass_cnt++;
            if (prev_rd) exp_rd = prev_rv;
            total_cnt++; if (rdata !== exp_rd) $display("FAIL rnd_rdata n%0d: got %h want %h", n, rdata, exp_rd); else pass_cnt++;
            total_cnt++; if (ext_if.rvalid !== prev_er) $display("FAIL rnd_rvalid n%0d: got %b want %b", n, ext_if.rvalid, prev_er); else pass_cnt++;
            if (prev_er) exp_erd = prev_ev;
            total_cnt++; if (ext_if.rdata !== exp_erd) $display("FAIL rnd_ext_rdata n%0d: got %h want %h", n, ext_if.rdata, exp_erd); else pass_cnt++;
            prev_rd = win == 2; prev_rv = rv;
            prev_er = win == 3 && !ext_if.we; prev_ev = ev;
        end
        idle(); step();
    endtask

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_strobe();
        test_rd_wr_collision();
        test_lr_sc();
        test_lr_ext_sc();
        test_starvation();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
